// File: rtl/r_ordering_pkg.sv
// Shared types for the R-channel ordering slice: uid layout,
// waiting-memory entry and default widths.
package r_ordering_pkg;

  localparam int R_ID_W   = 4;
  localparam int R_DATA_W = 64;
  localparam int R_RESP_W = 2;
  localparam int R_TAG_W  = 4;
  localparam int R_MAX_OUT = 16;
  localparam int R_ROW_W  = $clog2(R_MAX_OUT);
  localparam int R_COL_W  = $clog2(R_MAX_OUT);
  localparam int R_UID_W  = R_ROW_W + R_COL_W;

  typedef struct packed {
    logic [R_ROW_W-1:0] row;
    logic [R_COL_W-1:0] col;
  } r_uid_t;

  typedef struct packed {
    logic                valid;
    r_uid_t              uid;
    logic [R_ID_W-1:0]   id;
    logic [R_DATA_W-1:0] data;
    logic [R_RESP_W-1:0] resp;
    logic                last;
    logic [R_TAG_W-1:0]  tagid;
  } r_wm_entry_t;

endpackage

// File: rtl/r_wm_free_slot_finder.sv
// Priority encoder: lowest set bit of the free vector plus an any-free flag.
module r_wm_free_slot_finder #(
  parameter  int N     = 16,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     free,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/r_response_waiting_memory.sv
// Fully-associative parking store for out-of-order read responses.
// Optional sticky error checking under R_WM_ERR_CHECK_EN.
module r_response_waiting_memory
  import r_ordering_pkg::*;
#(
  parameter int ID_WIDTH        = R_ID_W,
  parameter int DATA_WIDTH      = R_DATA_W,
  parameter int RESP_WIDTH      = R_RESP_W,
  parameter int TAG_WIDTH       = R_TAG_W,
  parameter int MAX_OUTSTANDING = R_MAX_OUT,
  parameter int NUM_ROWS        = MAX_OUTSTANDING,
  parameter int NUM_COLS        = MAX_OUTSTANDING,
  parameter int UID_W = $clog2(NUM_ROWS) + $clog2(NUM_COLS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wm_write_en,
  input  logic [UID_W-1:0]      wm_write_uid,
  input  logic [ID_WIDTH-1:0]   wr_id,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [RESP_WIDTH-1:0] wr_resp,
  input  logic                  wr_last,
  input  logic [TAG_WIDTH-1:0]  wr_tagid,
  input  logic                  wm_release_en,
  input  logic [UID_W-1:0]      wm_release_uid,
  output logic                  rel_hit,
  output logic [ID_WIDTH-1:0]   rel_id,
  output logic [DATA_WIDTH-1:0] rel_data,
  output logic [RESP_WIDTH-1:0] rel_resp,
  output logic                  rel_last,
  output logic [TAG_WIDTH-1:0]  rel_tagid,
  output logic                  wm_full,
  output logic                  wm_empty,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] wm_count,
  output logic                  err_overflow,
  output logic                  err_dup,
  output logic                  err_miss
);

  localparam int N     = MAX_OUTSTANDING;
  localparam int CNT_W = $clog2(N + 1);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // Entry storage uses the package struct, so payload widths must agree.
  if (UID_W != R_UID_W || ID_WIDTH != R_ID_W ||
      DATA_WIDTH != R_DATA_W || RESP_WIDTH != R_RESP_W ||
      TAG_WIDTH != R_TAG_W) begin : g_width_err
    $error("payload/uid widths differ from r_ordering_pkg");
  end

  r_wm_entry_t mem [N];

  logic [N-1:0]     valid_vec;
  logic [N-1:0]     match_vec;
  logic [IDX_W-1:0] free_idx;
  logic             any_free;
  logic             dup_hit;
  logic             wr_acc;
  logic             rel_fire;
  logic [CNT_W-1:0] count_q;
  r_wm_entry_t      wr_entry;

  always_comb begin
    valid_vec = '0;
    match_vec = '0;
    for (int i = 0; i < N; i++) begin
      valid_vec[i] = mem[i].valid;
      match_vec[i] = mem[i].valid &&
                     (mem[i].uid == r_uid_t'(wm_release_uid));
    end
  end

  r_wm_free_slot_finder #(.N(N)) u_free (
    .free (~valid_vec),
    .idx  (free_idx),
    .any  (any_free)
  );

  always_comb begin
    rel_hit   = |match_vec;
    rel_id    = '0;
    rel_data  = '0;
    rel_resp  = '0;
    rel_last  = 1'b0;
    rel_tagid = '0;
    for (int i = 0; i < N; i++) begin
      if (match_vec[i]) begin
        rel_id    |= mem[i].id;
        rel_data  |= mem[i].data;
        rel_resp  |= mem[i].resp;
        rel_last  |= mem[i].last;
        rel_tagid |= mem[i].tagid;
      end
    end
  end

  always_comb begin
    wr_entry       = '0;
    wr_entry.valid = 1'b1;
    wr_entry.uid   = r_uid_t'(wm_write_uid);
    wr_entry.id    = wr_id;
    wr_entry.data  = wr_data;
    wr_entry.resp  = wr_resp;
    wr_entry.last  = wr_last;
    wr_entry.tagid = wr_tagid;
  end

  assign wr_acc   = wm_write_en && !wm_full && any_free && !dup_hit;
  assign rel_fire = wm_release_en && rel_hit;

  // Payload is deliberately left out of reset; only valid bits clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (rel_fire && match_vec[i]) mem[i].valid <= 1'b0;
      end
      if (wr_acc) mem[free_idx] <= wr_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (wr_acc && !rel_fire) begin
      count_q <= count_q + 1'b1;
    end else if (!wr_acc && rel_fire) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign wm_count = count_q;
  assign wm_full  = (count_q == CNT_W'(N));
  assign wm_empty = (count_q == '0);

`ifdef R_WM_ERR_CHECK_EN
  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (mem[i].valid && (mem[i].uid == r_uid_t'(wm_write_uid)))
        dup_hit = 1'b1;
    end
    dup_hit = dup_hit && wm_write_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_overflow <= 1'b0;
      err_dup      <= 1'b0;
      err_miss     <= 1'b0;
    end else begin
      if (wm_write_en && wm_full) err_overflow <= 1'b1;
      if (dup_hit) err_dup <= 1'b1;
      if (wm_release_en && !rel_hit) err_miss <= 1'b1;
    end
  end
`else
  assign dup_hit      = 1'b0;
  assign err_overflow = 1'b0;
  assign err_dup      = 1'b0;
  assign err_miss     = 1'b0;
`endif

endmodule

// File: tb/tb_r_response_waiting_memory.sv
// Randomized + directed bench for r_response_waiting_memory
// against a queue-based model of the parking store.
module tb_r_response_waiting_memory;

  localparam int MAXO = 4;
`ifdef R_WM_ERR_CHECK_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wm_write_en;
  logic [7:0]  wm_write_uid;
  logic [3:0]  wr_id;
  logic [63:0] wr_data;
  logic [1:0]  wr_resp;
  logic        wr_last;
  logic [3:0]  wr_tagid;
  logic        wm_release_en;
  logic [7:0]  wm_release_uid;
  logic        rel_hit;
  logic [3:0]  rel_id;
  logic [63:0] rel_data;
  logic [1:0]  rel_resp;
  logic        rel_last;
  logic [3:0]  rel_tagid;
  logic        wm_full;
  logic        wm_empty;
  logic [2:0]  wm_count;
  logic        err_overflow;
  logic        err_dup;
  logic        err_miss;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  uid;
    logic [74:0] pay;
  } ent_t;

  ent_t q[$];
  logic m_ovf, m_dup, m_miss;

  always #5 clk = ~clk;

  r_response_waiting_memory #(
    .MAX_OUTSTANDING(MAXO),
    .NUM_ROWS(16),
    .NUM_COLS(16)
  ) dut (
    .clk(clk), .rst(rst),
    .wm_write_en(wm_write_en), .wm_write_uid(wm_write_uid),
    .wr_id(wr_id), .wr_data(wr_data), .wr_resp(wr_resp),
    .wr_last(wr_last), .wr_tagid(wr_tagid),
    .wm_release_en(wm_release_en), .wm_release_uid(wm_release_uid),
    .rel_hit(rel_hit), .rel_id(rel_id), .rel_data(rel_data),
    .rel_resp(rel_resp), .rel_last(rel_last), .rel_tagid(rel_tagid),
    .wm_full(wm_full), .wm_empty(wm_empty), .wm_count(wm_count),
    .err_overflow(err_overflow), .err_dup(err_dup), .err_miss(err_miss)
  );

  function automatic int find(logic [7:0] u);
    foreach (q[i]) if (q[i].uid == u) return i;
    return -1;
  endfunction

  function automatic logic [74:0] obs_pay();
    return {rel_id, rel_data, rel_resp, rel_last, rel_tagid};
  endfunction

  function automatic logic [74:0] exp_pay(logic [7:0] u);
    int k;
    k = find(u);
    return (k >= 0) ? q[k].pay : 75'd0;
  endfunction

  task automatic drive(input bit we, input logic [7:0] wu,
                       input logic [63:0] d,
                       input bit re, input logic [7:0] ru);
    wm_write_en    = we;
    wm_write_uid   = wu;
    wr_data        = d;
    wr_id          = 4'($urandom);
    wr_resp        = 2'($urandom);
    wr_last        = 1'($urandom);
    wr_tagid       = 4'($urandom);
    wm_release_en  = re;
    wm_release_uid = ru;
    #1;
  endtask

  // Advance one clock and apply the store's rules to the model.
  task automatic tick();
    int  hi;
    bit  dupw, acc;
    ent_t e;
    hi   = find(wm_release_uid);
    dupw = (find(wm_write_uid) >= 0);
    acc  = wm_write_en && (q.size() < MAXO) && !(ERR && dupw);
    if (ERR) begin
      if (wm_write_en && q.size() == MAXO) m_ovf = 1'b1;
      if (wm_write_en && dupw) m_dup = 1'b1;
      if (wm_release_en && hi < 0) m_miss = 1'b1;
    end
    e.uid = wm_write_uid;
    e.pay = {wr_id, wr_data, wr_resp, wr_last, wr_tagid};
    @(posedge clk);
    #1;
    if (wm_release_en && hi >= 0) q.delete(hi);
    if (acc) q.push_back(e);
    drive(0, 8'h0, 64'h0, 0, 8'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 8'h0, 64'h0, 0, 8'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_ovf = 0; m_dup = 0; m_miss = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({wm_count, wm_empty, wm_full, rel_hit} !== 6'b000100) begin
      errors++;
      $display("FAIL reset_state: got cnt=%0d e=%b f=%b h=%b want 0 1 0 0",
               wm_count, wm_empty, wm_full, rel_hit);
    end
    checks++;
    if (obs_pay() !== 75'd0 ||
        {err_overflow, err_dup, err_miss} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outs: got pay=%h err=%b want 0 000",
               obs_pay(), {err_overflow, err_dup, err_miss});
    end
  endtask

  task automatic test_single();
    logic [74:0] ep;
    do_reset();
    drive(1, 8'h12, 64'hAA, 0, 8'h0);
    tick();
    drive(0, 8'h0, 64'h0, 1, 8'h12);
    ep = exp_pay(8'h12);
    checks++;
    if (rel_hit !== 1'b1 || rel_data !== 64'hAA) begin
      errors++;
      $display("FAIL single_hit: got hit=%b data=%h want 1 aa",
               rel_hit, rel_data);
    end
    checks++;
    if (obs_pay() !== ep) begin
      errors++;
      $display("FAIL single_pay: got %h want %h", obs_pay(), ep);
    end
    tick();
    checks++;
    if (wm_count !== 3'd0 || wm_empty !== 1'b1) begin
      errors++;
      $display("FAIL single_drain: got cnt=%0d e=%b want 0 1",
               wm_count, wm_empty);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 8'(i), 64'(i * 17), 0, 8'h0);
      tick();
    end
    checks++;
    if (wm_full !== 1'b1 || wm_count !== 3'd4 || wm_empty !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: got f=%b cnt=%0d e=%b want 1 4 0",
               wm_full, wm_count, wm_empty);
    end
    drive(1, 8'h05, 64'h55, 0, 8'h0);
    tick();
    checks++;
    if (wm_count !== 3'd4 || err_overflow !== m_ovf) begin
      errors++;
      $display("FAIL fill_overflow: got cnt=%0d ovf=%b want 4 %b",
               wm_count, err_overflow, m_ovf);
    end
    drive(0, 8'h0, 64'h0, 0, 8'h05);
    checks++;
    if (rel_hit !== 1'b0 || obs_pay() !== 75'd0) begin
      errors++;
      $display("FAIL fill_drop_miss: got hit=%b pay=%h want 0 0",
               rel_hit, obs_pay());
    end
  endtask

  task automatic test_simul();
    logic [74:0] ep;
    drive(1, 8'h05, 64'h500, 1, 8'h02);
    tick();
    checks++;
    if (wm_count !== 3'd3 || wm_full !== 1'b0) begin
      errors++;
      $display("FAIL simul_full_drop: got cnt=%0d f=%b want 3 0",
               wm_count, wm_full);
    end
    drive(1, 8'h06, 64'h600, 1, 8'h03);
    tick();
    checks++;
    if (wm_count !== 3'd3) begin
      errors++;
      $display("FAIL simul_swap: got cnt=%0d want 3", wm_count);
    end
    drive(0, 8'h0, 64'h0, 1, 8'h06);
    ep = exp_pay(8'h06);
    checks++;
    if (rel_hit !== 1'b1 || rel_data !== 64'h600 || obs_pay() !== ep) begin
      errors++;
      $display("FAIL simul_new_hit: got hit=%b pay=%h want 1 %h",
               rel_hit, obs_pay(), ep);
    end
    drive(0, 8'h0, 64'h0, 1, 8'h02);
    checks++;
    if (rel_hit !== 1'b0) begin
      errors++;
      $display("FAIL simul_freed_gone: got hit=%b want 0", rel_hit);
    end
  endtask

  task automatic test_collision();
    do_reset();
    drive(1, 8'h21, 64'h2121, 1, 8'h21);
    checks++;
    if (rel_hit !== 1'b0) begin
      errors++;
      $display("FAIL coll_same_cycle: got hit=%b want 0", rel_hit);
    end
    tick();
    checks++;
    if (err_miss !== m_miss || wm_count !== 3'd1) begin
      errors++;
      $display("FAIL coll_flag: got miss=%b cnt=%0d want %b 1",
               err_miss, wm_count, m_miss);
    end
    drive(0, 8'h0, 64'h0, 1, 8'h21);
    checks++;
    if (rel_hit !== 1'b1 || rel_data !== 64'h2121) begin
      errors++;
      $display("FAIL coll_next_hit: got hit=%b data=%h want 1 2121",
               rel_hit, rel_data);
    end
  endtask

  task automatic test_dup();
    do_reset();
    drive(1, 8'h30, 64'h3, 0, 8'h0);
    tick();
    drive(1, 8'h30, 64'h3, 0, 8'h0);
    tick();
    checks++;
    if (wm_count !== 3'(q.size()) || err_dup !== m_dup) begin
      errors++;
      $display("FAIL dup_write: got cnt=%0d dup=%b want %0d %b",
               wm_count, err_dup, q.size(), m_dup);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'(8'h40 + i), 64'(i), 0, 8'h0);
      tick();
    end
    drive(0, 8'h0, 64'h0, 1, 8'h41);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (wm_count !== 3'd0 || rel_hit !== 1'b0 || wm_empty !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_async: got cnt=%0d hit=%b e=%b want 0 0 1",
               wm_count, rel_hit, wm_empty);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_ovf = 0; m_dup = 0; m_miss = 0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 8'h0, 64'h0, 0, 8'(8'h40 + i));
      checks++;
      if (rel_hit !== 1'b0 || obs_pay() !== 75'd0) begin
        errors++;
        $display("FAIL rstmid_gone: uid=%h got hit=%b want 0",
                 8'h40 + i, rel_hit);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] wu, ru;
    bit we, re;
    bit ehit;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      we = ($urandom_range(0, 99) < 55);
      re = ($urandom_range(0, 99) < 45);
      wu = 8'($urandom_range(0, 11));
      if (!ERR) begin
        for (int t = 0; t < 16 && find(wu) >= 0; t++)
          wu = 8'($urandom_range(0, 11));
        if (find(wu) >= 0) we = 0;
      end
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        ru = q[$urandom_range(0, q.size() - 1)].uid;
      else
        ru = 8'($urandom_range(0, 11));
      drive(we, wu, {$urandom, $urandom}, re, ru);
      ehit = (find(ru) >= 0);
      checks++;
      if (rel_hit !== ehit || obs_pay() !== exp_pay(ru)) begin
        errors++;
        $display("FAIL rand_lookup: n=%0d uid=%h got %b/%h want %b/%h",
                 n, ru, rel_hit, obs_pay(), ehit, exp_pay(ru));
      end
      checks++;
      if (wm_count !== 3'(q.size()) ||
          wm_full !== (q.size() == MAXO) ||
          wm_empty !== (q.size() == 0)) begin
        errors++;
        $display("FAIL rand_occ: n=%0d got cnt=%0d f=%b e=%b want %0d",
                 n, wm_count, wm_full, wm_empty, q.size());
      end
      checks++;
      if ({err_overflow, err_dup, err_miss} !== {m_ovf, m_dup, m_miss}) begin
        errors++;
        $display("FAIL rand_flags: n=%0d got %b want %b", n,
                 {err_overflow, err_dup, err_miss}, {m_ovf, m_dup, m_miss});
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    m_ovf = 0; m_dup = 0; m_miss = 0;
    drive(0, 8'h0, 64'h0, 0, 8'h0);
    test_reset();
    test_single();
    test_fill();
    test_simul();
    test_collision();
    test_dup();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
